// File: rtl/ripple_adder_32.sv
// rtl/ripple_adder_32.sv - 32-bit gate-level ripple-carry adder with registered sum and carry-out

// One full-adder bit built only from gate primitives (xor/and/or).
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    wire w_p;
    wire w_g;
    wire w_t;

    xor u_xor_p (w_p, i_a, i_b);
    xor u_xor_s (o_s, w_p, i_c);
    and u_and_g (w_g, i_a, i_b);
    and u_and_t (w_t, w_p, i_c);
    or  u_or_c  (o_c, w_g, w_t);

endmodule

module ripple_adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    wire [WIDTH:0]   w_c;
    wire [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    assign w_c[0] = cin;

    // Carry chain: each cell feeds its carry strictly into the next higher bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_fa (
                .i_a (a[gi]),
                .i_b (b[gi]),
                .i_c (w_c[gi]),
                .o_s (w_sum[gi]),
                .o_c (w_c[gi+1])
            );
        end
    endgenerate

    // Output register: loads the combinational result every edge, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH];
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

endmodule

// File: tb/tb_ripple_adder_32.sv
// tb/tb_ripple_adder_32.sv - directed self-checking bench for ripple_adder_32

module tb_ripple_adder_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;

    int total;
    int bad;
    logic [32:0] prev_exp;

    ripple_adder_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] exp);
        logic [32:0] obs;
        obs = {cout, s};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={cout,s}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a vector between edges, confirm the register still holds the previous
    // result, then confirm the new result one edge later.
    task automatic apply(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [32:0] exp);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        #1;
        chk({tag, "_hold"}, prev_exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
        prev_exp = exp;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        rst_n = 1'b0;
        a     = 32'd5;
        b     = 32'd3;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 33'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_release_pre", 33'h0);
        @(posedge clk);
        #1;
        chk("reset_first", 33'd9);
        prev_exp = 33'd9;

        for (int i = 7; i <= 16; i++)
            apply("double", 32'(i), 32'(i), 1'b0, 33'(2 * i));

        for (int j = 2; j <= 18; j++)
            apply("cin_sweep", 32'd16, 32'(j), 1'b1, 33'(j + 17));

        apply("zero", 32'h0, 32'h0, 1'b0, 33'h0);
        apply("ff_plus_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 33'h1_0000_0000);
        apply("ff_cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 33'h1_0000_0000);
        apply("ff_ff_cin", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        apply("msb_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
        apply("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
        apply("alt_nocin", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
        apply("mixed", 32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);
        apply("wrap_low", 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 33'h1_0000_0010);

        // Back-to-back distinct values, each must land exactly one edge later.
        apply("b2b_0", 32'd1000, 32'd1, 1'b0, 33'd1001);
        apply("b2b_1", 32'd2000, 32'd2, 1'b1, 33'd2003);
        apply("b2b_2", 32'd3000, 32'd3, 1'b0, 33'd3003);
        apply("b2b_3", 32'd4000, 32'd4, 1'b1, 33'd4005);

        // Asynchronous reset between edges while the output is nonzero.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear", 33'h0);
        @(posedge clk);
        #1;
        chk("async_hold_edge", 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a     = 32'd100;
        b     = 32'd23;
        cin   = 1'b0;
        #1;
        chk("async_release_pre", 33'h0);
        @(posedge clk);
        #1;
        chk("async_resume", 33'd123);
        prev_exp = 33'd123;
        apply("after_resume", 32'd7, 32'd8, 1'b1, 33'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
